// File: rtl/uart_pkg.sv
// UART shared definitions: receive FSM encoding and default rates/depths.
// Also used by the transmit side.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on empty is ignored, and a push on full
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling, feeding a small show-ahead FIFO
// whose head is presented to the peripheral register/IRQ logic.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baud_tick,
  input  logic             UART_RX,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic [7:0]       RX_DATA,
  output logic             RX_STATUS,
  output logic [CNT_W-1:0] rx_count,
  output logic             overrun,
  output logic             frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);

  rx_state_t     r_state;
  logic          r_sync1;
  logic          r_rx_s;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_overrun;
  logic          r_frame_err;

  logic          w_empty;
  logic          w_full;
  logic          w_bit_end;
  logic          w_mid_start;
  logic          w_frame_evt;
  logic          w_ovr_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= UART_RX;
      r_rx_s  <= r_sync1;
    end
  end

  assign w_bit_end   = baud_tick && (r_tcnt == TW'(OVERSAMPLE - 1));
  assign w_mid_start = baud_tick && (r_tcnt == TW'(OVERSAMPLE / 2 - 1));
  assign w_frame_evt = (r_state == STOP) && w_bit_end && !r_rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (baud_tick && !r_rx_s) begin
            r_state <= START;
            r_tcnt  <= '0;
          end
        end
        START: begin
          if (w_mid_start) begin
            r_tcnt <= '0;
            r_bcnt <= '0;
            r_state <= r_rx_s ? IDLE : DATA;
          end else if (baud_tick) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_tcnt  <= '0;
            if (r_bcnt == 3'd7)
              r_state <= STOP;
            else
              r_bcnt <= r_bcnt + 3'd1;
          end else if (baud_tick) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_tcnt <= '0;
            if (r_rx_s) begin
              r_push      <= 1'b1;
              r_push_data <= r_shift;
              r_state     <= IDLE;
            end else begin
              r_state <= WAIT_HIGH;
            end
          end else if (baud_tick) begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not look like a new start bit.
          if (baud_tick && r_rx_s)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so no overrun then.
  assign w_ovr_evt = r_push && w_full && !rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_evt)
        r_overrun <= 1'b1;
      else if (clr_err)
        r_overrun <= 1'b0;
      if (w_frame_evt)
        r_frame_err <= 1'b1;
      else if (clr_err)
        r_frame_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_push),
    .pop   (rd_en),
    .din   (r_push_data),
    .dout  (RX_DATA),
    .empty (w_empty),
    .full  (w_full),
    .count (rx_count)
  );

  assign RX_STATUS = !w_empty;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames, glitch, overrun, framing,
// full push+pop and reset mid-frame.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic       UART_RX = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic [2:0] rx_count;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  bit popped_on_push;

  uart_rx_buffered #(
    .OVERSAMPLE (16),
    .FIFO_DEPTH (4),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .UART_RX   (UART_RX),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .RX_DATA   (RX_DATA),
    .RX_STATUS (RX_STATUS),
    .rx_count  (rx_count),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      baud_tick = (c == 0);
      c = (c + 1) % 4;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    UART_RX = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v,
                      input bit pop_on_push);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++)
      hold(d[i], BIT_CLK);
    UART_RX = stop_v;
    for (int i = 0; i < BIT_CLK; i++) begin
      if (pop_on_push && dut.r_push && !popped_on_push) begin
        rd_en = 1'b1;
        popped_on_push = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
    end
    rd_en = 1'b0;
    UART_RX = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, RX_DATA, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", RX_DATA, 8'h00);
    chk("rst_stat", RX_STATUS, 1'b0);
    chk("rst_cnt", rx_count, 3'd0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // single frame
    send(8'hA5, 1'b1, 1'b0);
    chk("a5_stat", RX_STATUS, 1'b1);
    chk("a5_data", RX_DATA, 8'hA5);
    chk("a5_cnt", rx_count, 3'd1);
    pop_chk("a5_pop", 8'hA5);
    chk("a5_stat0", RX_STATUS, 1'b0);
    chk("a5_data0", RX_DATA, 8'h00);
    chk("a5_cnt0", rx_count, 3'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("underflow_cnt", rx_count, 3'd0);

    // glitch: low for 5 ticks
    hold(1'b0, 20);
    hold(1'b1, 200);
    chk("gl_state", dut.r_state, IDLE);
    chk("gl_cnt", rx_count, 3'd0);
    chk("gl_ovr", overrun, 1'b0);
    chk("gl_ferr", frame_err, 1'b0);

    // overrun
    for (int i = 1; i <= 5; i++)
      send(8'(i), 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("ov_cnt", rx_count, 3'd4);
    chk("ov_flag", overrun, 1'b1);
    for (int i = 1; i <= 4; i++)
      pop_chk("ov_pop", 8'(i));
    chk("ov_empty", RX_STATUS, 1'b0);
    pulse_clr();
    chk("ov_clr", overrun, 1'b0);

    // framing error with break
    send(8'h3C, 1'b0, 1'b0);
    hold(1'b0, 160);
    hold(1'b1, 1500);
    chk("fe_flag", frame_err, 1'b1);
    chk("fe_cnt", rx_count, 3'd0);
    chk("fe_state", dut.r_state, IDLE);
    pulse_clr();
    chk("fe_clr", frame_err, 1'b0);

    // full push + pop
    for (int i = 0; i < 4; i++)
      send(8'h10 + 8'(i), 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("fp_full", rx_count, 3'd4);
    popped_on_push = 1'b0;
    send(8'h14, 1'b1, 1'b1);
    hold(1'b1, 20);
    chk("fp_fired", popped_on_push, 1'b1);
    chk("fp_ovr", overrun, 1'b0);
    chk("fp_cnt", rx_count, 3'd4);
    for (int i = 1; i <= 4; i++)
      pop_chk("fp_pop", 8'h10 + 8'(i));
    chk("fp_empty", rx_count, 3'd0);

    // reset during data bit 3 of 0xFF
    send(8'h77, 1'b1, 1'b0);
    hold(1'b1, 20);
    hold(1'b0, BIT_CLK);
    hold(1'b1, 3 * BIT_CLK + 32);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_data", RX_DATA, 8'h00);
    chk("mr_stat", RX_STATUS, 1'b0);
    chk("mr_cnt", rx_count, 3'd0);
    chk("mr_ovr", overrun, 1'b0);
    chk("mr_ferr", frame_err, 1'b0);
    chk("mr_state", dut.r_state, IDLE);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    hold(1'b1, 5 * BIT_CLK + 32);
    chk("mr_quiet", rx_count, 3'd0);
    send(8'h5A, 1'b1, 1'b0);
    hold(1'b1, 20);
    chk("mr_cnt1", rx_count, 3'd1);
    chk("mr_5a", RX_DATA, 8'h5A);
    chk("mr_noerr", frame_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
